// File: rtl/bufg_gt_div_pkg.sv
// ---------------------------------------------------------------------------
// bufg_gt_div_pkg
// Shared constants for the GT clock-buffer simulation models.
//   DIV_W      : width of the run-time divide-ratio field (ratio = DIV+1).
//   SCOPE_*    : cell_kind codes that identify each primitive model.
//   CELL_KIND  : cell_kind of the GT buffer with divider (fed from the
//                reference-clock input buffer O/ODIV2, hence SCOPE_IQ).
// No ports.
// ---------------------------------------------------------------------------
package bufg_gt_div_pkg;

   localparam int DIV_W = 3;

   localparam int SCOPE_IBUF = 0;
   localparam int SCOPE_IQ   = 1;
   localparam int SCOPE_OQ   = 2;

   localparam int CELL_KIND  = SCOPE_IQ;

endpackage : bufg_gt_div_pkg

// File: rtl/bufg_gt_div_ce_sync.sv
// ---------------------------------------------------------------------------
// gt_ce_sync
// Parameterised-depth flop chain for a clock-enable input, with synchronous
// clear. STAGES = 0 makes it a pure pass-through. Shared by the CE inputs of
// the GT buffer models.
// Ports:
//   clk : sampling clock (posedge)
//   clr : synchronous active-high clear, forces every stage to 0
//   d   : asynchronous enable in
//   q   : enable delayed by STAGES clk edges
// ---------------------------------------------------------------------------
module gt_ce_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   generate
      if (STAGES == 0) begin : g_bypass
         assign q = d;
      end else begin : g_chain
         logic [STAGES-1:0] sr;

         always_ff @(posedge clk) begin
            if (clr) begin
               sr <= '0;
            end else begin
               sr[0] <= d;
               for (int i = 1; i < STAGES; i++) begin
                  sr[i] <= sr[i-1];
               end
            end
         end

         assign q = sr[STAGES-1];
      end
   endgenerate

endmodule : gt_ce_sync

// File: rtl/bufg_gt_div.sv
// ---------------------------------------------------------------------------
// bufg_gt_div
// Simulation model of the GT clock buffer with integer divider (1..8).
// Ports:
//   I       : input clock, all state updates on posedge I
//   CLR     : synchronous active-high reset (sampled on posedge I)
//   CE      : clock enable, active-high, passes through CE_SYNC_STAGES flops
//   CEMASK  : 1 = CE ignored and treated as 1
//   CLRMASK : 1 = CLR ignored and treated as 0
//   DIV     : divide ratio minus one, latched only at period boundaries
//   O       : divided, gated output clock
// Divide-by-N (N>1): ceil(N/2) high cycles then floor(N/2) low cycles.
// Divide-by-1: O = I gated by an enable captured on negedge I, so the gate
// only moves while I is low and no runt pulse can appear.
// ---------------------------------------------------------------------------
module bufg_gt_div
   import bufg_gt_div_pkg::*;
#(
   parameter int   CE_SYNC_STAGES = 2,
   parameter logic O_INIT         = 1'b0
) (
   input  logic             I,
   input  logic             CLR,
   input  logic             CE,
   input  logic             CEMASK,
   input  logic             CLRMASK,
   input  logic [DIV_W-1:0] DIV,
   output logic             O
);

   logic             clr_e;
   logic             ce_s;
   logic             ce_e;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] hi;
   logic             o_q;
   logic             ce_n;
   logic             rst_q;
   logic             boundary;

   assign clr_e = CLR & ~CLRMASK;

   gt_ce_sync #(
      .STAGES (CE_SYNC_STAGES)
   ) u_ce_sync (
      .clk (I),
      .clr (clr_e),
      .d   (CE),
      .q   (ce_s)
   );

   assign ce_e = ce_s | CEMASK;

   // (div_q+2)>>1 rewritten as (div_q>>1)+1 so it fits DIV_W bits.
   assign hi       = (div_q >> 1) + DIV_W'(1);
   assign boundary = (cnt == div_q);

   always_ff @(posedge I) begin
      rst_q <= clr_e;
      if (clr_e) begin
         cnt   <= '0;
         div_q <= DIV;
         o_q   <= O_INIT;
      end else if (ce_e) begin
         if (div_q == '0) begin
            // Every edge is a boundary at N=1; keep cnt parked at 0 so the
            // normal rule starts cleanly if DIV moves away from 0.
            cnt   <= '0;
            o_q   <= 1'b0;
            div_q <= DIV;
         end else begin
            o_q <= (cnt < hi);
            if (boundary) begin
               cnt   <= '0;
               div_q <= DIV;
            end else begin
               cnt <= cnt + DIV_W'(1);
            end
         end
      end
   end

   // Divide-by-1 gate, captured while I is low.
   always_ff @(negedge I) begin
      if (clr_e) begin
         ce_n <= 1'b0;
      end else begin
         ce_n <= ce_e;
      end
   end

   // rst_q forces O_INIT from the reset edge even in divide-by-1 mode, where
   // ce_n would otherwise only clear on the following falling edge.
   assign O = rst_q ? O_INIT : ((div_q == '0) ? (I & ce_n) : o_q);

endmodule : bufg_gt_div

// File: tb/tb_bufg_gt_div.sv
// ---------------------------------------------------------------------------
// tb_bufg_gt_div
// Directed bench for bufg_gt_div with hand-computed O sequences. Inputs are
// driven 1 time unit after a rising edge; O is sampled at the same point.
// ---------------------------------------------------------------------------
module tb_bufg_gt_div;

   logic       I;
   logic       CLR;
   logic       CE;
   logic       CEMASK;
   logic       CLRMASK;
   logic [2:0] DIV;
   logic       O;

   int errors = 0;
   int checks = 0;
   logic exp_q[$];

   bufg_gt_div #(
      .CE_SYNC_STAGES (2),
      .O_INIT         (1'b0)
   ) dut (
      .I       (I),
      .CLR     (CLR),
      .CE      (CE),
      .CEMASK  (CEMASK),
      .CLRMASK (CLRMASK),
      .DIV     (DIV),
      .O       (O)
   );

   // clock / watchdog
   initial begin
      I = 1'b0;
      forever #5 I = ~I;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: O=%b expected %b at t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge I);
      #1;
   endtask

   // Reset with DIV=d for three edges, check O, then release.
   task automatic do_reset(input logic [2:0] d);
      CLR = 1'b1;
      DIV = d;
      repeat (3) tick();
      check("reset_o", O, 1'b0);
      CLR = 1'b0;
   endtask

   // One posedge per queued expectation.
   task automatic run_seq(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1'b1, 1'b0);
         end else begin
            check(tag, O, exp_q.pop_front());
         end
      end
   endtask

   task automatic push(input string pat);
      for (int k = 0; k < pat.len(); k++) begin
         exp_q.push_back(pat[k] == "1");
      end
   endtask

   // Divide-by-1 cycle: low phase must be 0, whole high phase must be exp.
   task automatic div1_cycle(input logic exp);
      @(negedge I);
      #1;
      check("div1_low", O, 1'b0);
      @(posedge I);
      #1;
      check("div1_high_early", O, exp);
      #3;
      check("div1_high_late", O, exp);
   endtask

   initial begin
      CLR     = 1'b1;
      CE      = 1'b1;
      CEMASK  = 1'b0;
      CLRMASK = 1'b0;
      DIV     = 3'd1;

      // 1: divide-by-2 after reset, first high on 3rd edge after release
      do_reset(3'd1);
      push("001010");
      run_seq("t1_div2", 6);

      // 2: divide-by-3, then DIV=7 mid-period
      do_reset(3'd2);
      push("001101101");
      run_seq("t2_div3", 9);
      DIV = 3'd7;
      push("10111100001");
      run_seq("t2_div8", 11);

      // 3: divide-by-4 with CE low for 5 edges while O high
      do_reset(3'd3);
      push("0");
      run_seq("t3_pre", 1);
      CE = 1'b0;
      push("01111");
      run_seq("t3_hold", 5);
      CE = 1'b1;
      push("11100110");
      run_seq("t3_resume", 8);

      // 4: divide-by-1 gating, CE toggled while I high
      do_reset(3'd0);
      div1_cycle(1'b0);
      div1_cycle(1'b0);
      div1_cycle(1'b1);
      CE = 1'b0;
      div1_cycle(1'b1);
      div1_cycle(1'b1);
      div1_cycle(1'b0);
      CE = 1'b1;
      div1_cycle(1'b0);
      div1_cycle(1'b0);
      div1_cycle(1'b1);
      div1_cycle(1'b1);

      // 5: CLRMASK hides CLR, CEMASK hides CE
      do_reset(3'd1);
      push("001010");
      run_seq("t5_base", 6);
      CLRMASK = 1'b1;
      CLR     = 1'b1;
      push("1010");
      run_seq("t5_clrmask", 4);
      CEMASK = 1'b1;
      CE     = 1'b0;
      push("101010");
      run_seq("t5_cemask", 6);
      CLR     = 1'b0;
      CLRMASK = 1'b0;
      CE      = 1'b1;

      // 6: reset mid-period of divide-by-5 with new DIV=1 (CEMASK on)
      do_reset(3'd4);
      push("11");
      run_seq("t6_div5", 2);
      CLR = 1'b1;
      DIV = 3'd1;
      push("0");
      run_seq("t6_abort", 1);
      CLR = 1'b0;
      push("1010");
      run_seq("t6_div2", 4);
      CEMASK = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_bufg_gt_div
